// File: rtl/tdm_demux_1x16_if.sv
// Serial-link side and parallel-word side of the 1:16 TDM demultiplexer.
// master drives the serial bit stream; slave is the demultiplexer itself.
interface tdm_demux_1x16_if;
   logic        din;
   logic        din_valid;
   logic        sync;
   logic [15:0] dout;
   logic        dout_valid;
   logic [3:0]  slot;
   logic        locked;
   logic        sync_err;

   modport master (
      output din, din_valid, sync,
      input  dout, dout_valid, slot, locked, sync_err
   );

   modport slave (
      input  din, din_valid, sync,
      output dout, dout_valid, slot, locked, sync_err
   );
endinterface

// File: rtl/tdm_demux_1x16.sv
// Registered 1:16 TDM demultiplexer: assembles 16 slot bits into dout, strobing dout_valid on the slot-15 edge.
// din_valid=0 stalls everything; there is no backpressure toward the serial link.
module tdm_demux_1x16 #(
   parameter bit SYNC_REQ = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   tdm_demux_1x16_if.slave   bus
);
   typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

   state_t      state;
   logic [15:0] asm_q;
   logic [15:0] dout_q;
   logic        dout_valid_q;
   logic [3:0]  slot_q;
   logic        sync_err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= HUNT;
         asm_q        <= 16'h0000;
         dout_q       <= 16'h0000;
         dout_valid_q <= 1'b0;
         slot_q       <= 4'd0;
         sync_err_q   <= 1'b0;
      end else begin
         dout_valid_q <= 1'b0;
         sync_err_q   <= 1'b0;
         if (bus.din_valid) begin
            case (state)
               HUNT: begin
                  if (bus.sync) begin
                     asm_q[0] <= bus.din;
                     slot_q   <= 4'd1;
                     state    <= LOCKED;
                  end
               end
               LOCKED: begin
                  // Misplaced sync wins over everything, including slot 15 completion.
                  if (bus.sync && slot_q != 4'd0) begin
                     sync_err_q <= 1'b1;
                     asm_q[0]   <= bus.din;
                     slot_q     <= 4'd1;
                  end else if (slot_q == 4'd0 && !bus.sync && SYNC_REQ) begin
                     sync_err_q <= 1'b1;
                     slot_q     <= 4'd0;
                     state      <= HUNT;
                  end else if (slot_q == 4'd15) begin
                     asm_q[15]    <= bus.din;
                     dout_q       <= {bus.din, asm_q[14:0]};
                     dout_valid_q <= 1'b1;
                     slot_q       <= 4'd0;
                  end else begin
                     asm_q[slot_q] <= bus.din;
                     slot_q        <= slot_q + 4'd1;
                  end
               end
               default: begin
                  state  <= HUNT;
                  slot_q <= 4'd0;
               end
            endcase
         end
      end
   end

   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.slot       = slot_q;
   assign bus.locked     = (state == LOCKED);
   assign bus.sync_err   = sync_err_q;
endmodule

// File: tb/tb_tdm_demux_1x16.sv
// Bench for tdm_demux_1x16: one instance with SYNC_REQ=0 (a) and one with SYNC_REQ=1 (b).
// Completed words are checked against a scoreboard queue filled when the slot-15 bit is driven.
module tb_tdm_demux_1x16;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tdm_demux_1x16_if a_bus ();
   tdm_demux_1x16_if b_bus ();

   tdm_demux_1x16 #(.SYNC_REQ(1'b0)) u_a (.clk(clk), .rst(rst), .bus(a_bus));
   tdm_demux_1x16 #(.SYNC_REQ(1'b1)) u_b (.clk(clk), .rst(rst), .bus(b_bus));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int a_last = -100, a_gap = 0;
   int b_last = -100;
   logic [15:0] qa[$];
   logic [15:0] qb[$];

   typedef struct {
      logic        d, v, s;
      logic [3:0]  slot;
      logic        locked, err, dv;
      logic [15:0] word;
   } vec_t;
   vec_t tbl[64];
   int   n_vec = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every dout_valid strobe must match the oldest pending word.
   always @(negedge clk) begin
      if (a_bus.dout_valid === 1'b1) begin
         a_gap = cyc - a_last;
         a_last = cyc;
         check("a_dv_not_consecutive", 32'(a_gap > 1), 32'd1);
         if (qa.size() == 0) begin
            total++; bad++;
            $display("FAIL a_unexpected_word: got %h expected no word", a_bus.dout);
         end else check("a_word", 32'(a_bus.dout), 32'(qa.pop_front()));
      end
      if (b_bus.dout_valid === 1'b1) begin
         check("b_dv_not_consecutive", 32'((cyc - b_last) > 1), 32'd1);
         b_last = cyc;
         if (qb.size() == 0) begin
            total++; bad++;
            $display("FAIL b_unexpected_word: got %h expected no word", b_bus.dout);
         end else check("b_word", 32'(b_bus.dout), 32'(qb.pop_front()));
      end
   end

   task automatic drive(input int which, input logic d, input logic v, input logic s);
      a_bus.din_valid = 1'b0;
      b_bus.din_valid = 1'b0;
      if (which == 0) begin
         a_bus.din = d; a_bus.din_valid = v; a_bus.sync = s;
      end else begin
         b_bus.din = d; b_bus.din_valid = v; b_bus.sync = s;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int which, input logic [15:0] w, input logic sync_first,
                             input int gaps);
      int gs[$];
      for (int j = 0; j < gaps; j++) gs.push_back(int'($urandom_range(15, 1)));
      for (int k = 0; k < 16; k++) begin
         foreach (gs[j]) if (gs[j] == k) drive(which, 1'($urandom), 1'b0, 1'($urandom));
         if (k == 15) begin
            if (which == 0) qa.push_back(w); else qb.push_back(w);
         end
         drive(which, w[k], 1'b1, (k == 0) && sync_first);
      end
   endtask

   task automatic add(input logic d, input logic v, input logic s, input logic [3:0] sl,
                      input logic lk, input logic er, input logic dv, input logic [15:0] wd);
      tbl[n_vec] = '{d: d, v: v, s: s, slot: sl, locked: lk, err: er, dv: dv, word: wd};
      n_vec++;
   endtask

   initial begin
      logic [15:0] w;
      rst = 1'b1;
      a_bus.din = 0; a_bus.din_valid = 0; a_bus.sync = 0;
      b_bus.din = 0; b_bus.din_valid = 0; b_bus.sync = 0;

      // Vector table: HUNT discard, A5C3 frame, idle/ignored sync, partial frame broken at slot 7, 8001 frame.
      add(1, 1, 0, 4'd0, 0, 0, 0, 16'h0);
      add(0, 1, 0, 4'd0, 0, 0, 0, 16'h0);
      w = 16'hA5C3;
      for (int k = 0; k < 16; k++) add(w[k], 1, k == 0, 4'(k + 1), 1, 0, k == 15, w);
      add(0, 0, 1, 4'd0, 1, 0, 0, 16'h0);
      add(1, 0, 0, 4'd0, 1, 0, 0, 16'h0);
      w = 16'h7777;
      for (int k = 0; k < 7; k++) add(w[k], 1, k == 0, 4'(k + 1), 1, 0, 0, 16'h0);
      add(1, 1, 1, 4'd1, 1, 1, 0, 16'h0);
      w = 16'h8001;
      for (int k = 1; k < 16; k++) add(w[k], 1, 0, 4'(k + 1), 1, 0, k == 15, w);

      #12;
      @(negedge clk);
      check("rst_dout", 32'(a_bus.dout), 32'h0);
      check("rst_dout_valid", 32'(a_bus.dout_valid), 32'h0);
      check("rst_slot", 32'(a_bus.slot), 32'h0);
      check("rst_locked", 32'(a_bus.locked), 32'h0);
      check("rst_sync_err", 32'(a_bus.sync_err), 32'h0);
      #1 rst = 1'b0;

      for (int i = 0; i < n_vec; i++) begin
         if (tbl[i].dv) qa.push_back(tbl[i].word);
         drive(0, tbl[i].d, tbl[i].v, tbl[i].s);
         check($sformatf("vec%0d_slot", i), 32'(a_bus.slot), 32'(tbl[i].slot));
         check($sformatf("vec%0d_locked", i), 32'(a_bus.locked), 32'(tbl[i].locked));
         check($sformatf("vec%0d_sync_err", i), 32'(a_bus.sync_err), 32'(tbl[i].err));
         check($sformatf("vec%0d_dout_valid", i), 32'(a_bus.dout_valid), 32'(tbl[i].dv));
      end
      drive(0, 0, 0, 0);
      check("dout_hold_8001", 32'(a_bus.dout), 32'h8001);

      // Back-to-back frames, sync only on the first, then a stalled frame.
      send_frame(0, 16'h1234, 1'b1, 0);
      send_frame(0, 16'hFFFF, 1'b0, 0);
      @(negedge clk); #1;
      check("gap_back_to_back", 32'(a_gap), 32'd16);
      send_frame(0, 16'h00FF, 1'b0, 3);
      @(negedge clk); #1;
      check("gap_stalled", 32'(a_gap), 32'd19);
      check("dout_00ff", 32'(a_bus.dout), 32'h00FF);

      // SYNC_REQ=1: missing sync on slot 0 drops lock.
      send_frame(1, 16'hC3A5, 1'b1, 0);
      drive(1, 1, 1, 0);
      check("req_sync_err", 32'(b_bus.sync_err), 32'd1);
      check("req_locked", 32'(b_bus.locked), 32'd0);
      check("req_slot", 32'(b_bus.slot), 32'd0);
      for (int k = 0; k < 15; k++) drive(1, 1'($urandom), 1'b1, 1'b0);
      check("req_hunt_slot", 32'(b_bus.slot), 32'd0);
      check("req_hunt_locked", 32'(b_bus.locked), 32'd0);
      check("req_hunt_err", 32'(b_bus.sync_err), 32'd0);
      check("req_hold_dout", 32'(b_bus.dout), 32'hC3A5);
      send_frame(1, 16'h3C3C, 1'b1, 0);
      @(negedge clk); #1;
      check("req_relock", 32'(b_bus.locked), 32'd1);

      // Asynchronous reset mid-frame at slot 9.
      w = 16'hFFFF;
      for (int k = 0; k < 9; k++) drive(0, w[k], 1'b1, k == 0);
      check("pre_rst_slot", 32'(a_bus.slot), 32'd9);
      #2 rst = 1'b1;
      #1;
      check("arst_dout", 32'(a_bus.dout), 32'h0);
      check("arst_slot", 32'(a_bus.slot), 32'h0);
      check("arst_locked", 32'(a_bus.locked), 32'h0);
      check("arst_dout_valid", 32'(a_bus.dout_valid), 32'h0);
      check("arst_sync_err", 32'(a_bus.sync_err), 32'h0);
      @(negedge clk); #1 rst = 1'b0;
      send_frame(0, 16'h5A5A, 1'b1, 0);
      @(negedge clk); #1;
      check("post_rst_dout", 32'(a_bus.dout), 32'h5A5A);

      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);
      check("a_queue_drained", 32'(qa.size()), 32'd0);
      check("b_queue_drained", 32'(qb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
